mmio_periph: RTL and testbench

MMIO_PERIPH -- requirements
Module: mmio_periph

---
 rtl/mmio_pkg.sv | 36 +++
 rtl/dec7seg.sv | 31 +++
 rtl/mmio_periph.sv | 143 ++++++++++++++
 tb/tb_mmio_periph.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped peripheral block: byte offsets,
// register-select codes (addr[5:2]) and timer control/status bit positions.
package mmio_pkg;

    // Byte offsets inside the I/O window
    localparam logic [7:0] OFF_LEDS    = 8'h04;
    localparam logic [7:0] OFF_HEX     = 8'h08;
    localparam logic [7:0] OFF_BLANK   = 8'h0C;
    localparam logic [7:0] OFF_SW      = 8'h10;
    localparam logic [7:0] OFF_SW_EDGE = 8'h14;
    localparam logic [7:0] OFF_TCOUNT  = 8'h18;
    localparam logic [7:0] OFF_TCMP    = 8'h1C;
    localparam logic [7:0] OFF_TCTRL   = 8'h20;
    localparam logic [7:0] OFF_TSTAT   = 8'h24;

    // Word-select codes, derived from the byte offsets so the two never drift
    typedef enum logic [3:0] {
        SEL_LEDS    = OFF_LEDS[5:2],
        SEL_HEX     = OFF_HEX[5:2],
        SEL_BLANK   = OFF_BLANK[5:2],
        SEL_SW      = OFF_SW[5:2],
        SEL_SW_EDGE = OFF_SW_EDGE[5:2],
        SEL_TCOUNT  = OFF_TCOUNT[5:2],
        SEL_TCMP    = OFF_TCMP[5:2],
        SEL_TCTRL   = OFF_TCTRL[5:2],
        SEL_TSTAT   = OFF_TSTAT[5:2]
    } reg_sel_e;

    // Timer control and status bit positions
    localparam int TCTRL_EN      = 0;
    localparam int TCTRL_IRQ_EN  = 1;
    localparam int TCTRL_RELOAD  = 2;
    localparam int TCTRL_WIDTH   = 3;
    localparam int TSTAT_PENDING = 0;

endpackage

// File: rtl/dec7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module dec7seg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure lookup table; a segment is lit when its bit is 0
    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped I/O block: LEDs, 7-segment digits with blanking, synchronized
// switches with sticky change flags, and a 32-bit compare timer with interrupt.
module mmio_periph
    import mmio_pkg::*;
#(
    parameter int LED_WIDTH = 10,
    parameter int NUM_HEX   = 6,
    parameter int SW_WIDTH  = 10,
    parameter int IO_BIT    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          addr,
    input  logic [31:0]          writedata,
    input  logic                 memwrite,
    input  logic [SW_WIDTH-1:0]  sw,
    output logic                 io_sel,
    output logic [31:0]          io_rdata,
    output logic [LED_WIDTH-1:0] leds,
    output logic [7*NUM_HEX-1:0] hex,
    output logic                 irq
);

    logic [LED_WIDTH-1:0]   r_leds;
    logic [4*NUM_HEX-1:0]   r_hex;
    logic [NUM_HEX-1:0]     r_blank;
    logic [SW_WIDTH-1:0]    r_sw_meta;
    logic [SW_WIDTH-1:0]    r_sw_sync;
    logic [SW_WIDTH-1:0]    r_sw_edge;
    logic [1:0]             r_arm;
    logic [31:0]            r_tcount;
    logic [31:0]            r_tcmp;
    logic [TCTRL_WIDTH-1:0] r_tctrl;
    logic                   r_pending;

    logic                   w_wr;
    logic [3:0]             w_sel;
    logic                   w_match;
    logic [SW_WIDTH-1:0]    w_sw_change;
    logic [SW_WIDTH-1:0]    w_sw_clr;
    logic                   w_pend_clr;
    logic                   w_unused_bits;

    assign io_sel  = addr[IO_BIT];
    assign w_wr    = memwrite & io_sel;
    assign w_sel   = addr[5:2];
    assign w_match = r_tctrl[TCTRL_EN] && (r_tcount == r_tcmp);

    // Change detection is held off until the synchronizer carries real samples,
    // so the first post-reset fill is not mistaken for a switch toggle.
    assign w_sw_change = (r_sw_meta ^ r_sw_sync) & {SW_WIDTH{r_arm[1]}};
    assign w_sw_clr    = (w_wr && (w_sel == SEL_SW_EDGE)) ? writedata[SW_WIDTH-1:0] : '0;
    assign w_pend_clr  = w_wr && (w_sel == SEL_TSTAT) && writedata[TSTAT_PENDING];

    assign leds = r_leds;
    assign irq  = r_pending & r_tctrl[TCTRL_IRQ_EN];

    // Upper address/data bits are intentionally ignored by this block
    assign w_unused_bits = ^{addr, writedata};

    // Plain CPU-writable configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_leds  <= '0;
            r_hex   <= '0;
            r_blank <= '0;
            r_tcmp  <= 32'hFFFF_FFFF;
            r_tctrl <= '0;
        end else if (w_wr) begin
            case (w_sel)
                SEL_LEDS:  r_leds  <= writedata[LED_WIDTH-1:0];
                SEL_HEX:   r_hex   <= writedata[4*NUM_HEX-1:0];
                SEL_BLANK: r_blank <= writedata[NUM_HEX-1:0];
                SEL_TCMP:  r_tcmp  <= writedata;
                SEL_TCTRL: r_tctrl <= writedata[TCTRL_WIDTH-1:0];
                default:   ;
            endcase
        end
    end

    // Switch synchronizer and sticky change flags (a new change beats a clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_sw_edge <= '0;
            r_arm     <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            r_arm     <= {r_arm[0], 1'b1};
            r_sw_edge <= (r_sw_edge & ~w_sw_clr) | w_sw_change;
        end
    end

    // Timer: CPU write beats auto-reload, which beats increment; match beats clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcount  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_wr && (w_sel == SEL_TCOUNT)) begin
                r_tcount <= writedata;
            end else if (w_match && r_tctrl[TCTRL_RELOAD]) begin
                r_tcount <= '0;
            end else if (r_tctrl[TCTRL_EN]) begin
                r_tcount <= r_tcount + 32'd1;
            end
            r_pending <= (r_pending & ~w_pend_clr) | w_match;
        end
    end

    // Read mux; unmapped offsets and bits above each register's width read 0
    always_comb begin
        io_rdata = '0;
        case (w_sel)
            SEL_LEDS:    io_rdata[LED_WIDTH-1:0]   = r_leds;
            SEL_HEX:     io_rdata[4*NUM_HEX-1:0]   = r_hex;
            SEL_BLANK:   io_rdata[NUM_HEX-1:0]     = r_blank;
            SEL_SW:      io_rdata[SW_WIDTH-1:0]    = r_sw_sync;
            SEL_SW_EDGE: io_rdata[SW_WIDTH-1:0]    = r_sw_edge;
            SEL_TCOUNT:  io_rdata                  = r_tcount;
            SEL_TCMP:    io_rdata                  = r_tcmp;
            SEL_TCTRL:   io_rdata[TCTRL_WIDTH-1:0] = r_tctrl;
            SEL_TSTAT:   io_rdata[TSTAT_PENDING]   = r_pending;
            default:     io_rdata = '0;
        endcase
    end

    // One decoder per digit; a blanked digit drives all segments off
    genvar gi;
    generate
        for (gi = 0; gi < NUM_HEX; gi++) begin : g_digit
            logic [6:0] w_seg;
            dec7seg u_dec (
                .i_nibble (r_hex[4*gi+3:4*gi]),
                .o_seg    (w_seg)
            );
            assign hex[7*gi+6:7*gi] = r_blank[gi] ? 7'h7F : w_seg;
        end
    endgenerate

endmodule

// File: tb/tb_mmio_periph.sv
// Directed self-checking bench for mmio_periph with default parameters.
module tb_mmio_periph;

    logic        clk;
    logic        reset_n;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [9:0]  sw;
    logic        io_sel;
    logic [31:0] io_rdata;
    logic [9:0]  leds;
    logic [41:0] hex;
    logic        irq;

    int tests;
    int fails;

    localparam logic [41:0] HEX_RST = {6{7'h40}};

    mmio_periph #(
        .LED_WIDTH (10),
        .NUM_HEX   (6),
        .SW_WIDTH  (10),
        .IO_BIT    (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .sw        (sw),
        .io_sel    (io_sel),
        .io_rdata  (io_rdata),
        .leds      (leds),
        .hex       (hex),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Called at a falling edge: the write lands on the next rising edge and
    // the task returns at the following falling edge.
    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        @(negedge clk);
        memwrite  = 1'b0;
        $display("[TB] write addr=%h data=%h", a, d);
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        addr     = a;
        memwrite = 1'b0;
        #1;
        d = io_rdata;
        $display("[TB] read  addr=%h data=%h", a, d);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        if (leds !== 10'h000) begin fails++; $display("FAIL reset_leds: got %h need %h", leds, 10'h000); end
        tests++;
        if (hex !== HEX_RST) begin fails++; $display("FAIL reset_hex: got %h need %h", hex, HEX_RST); end
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b need 0", irq); end
        tests++;
        cpu_read(32'h11C, rd);
        tests++;
        if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_tcmp: got %h need ffffffff", rd); end
        cpu_read(32'h118, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL reset_tcount: got %h need 0", rd); end
        tests++;
        if (io_sel !== 1'b1) begin fails++; $display("FAIL io_sel_hi: got %b need 1", io_sel); end
        addr = 32'h004;
        #1;
        tests++;
        if (io_sel !== 1'b0) begin fails++; $display("FAIL io_sel_lo: got %b need 0", io_sel); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Switches already high while in reset must not flag a change afterwards
    task automatic test_sw_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        sw      = 10'h005;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        cpu_read(32'h110, rd);
        tests++;
        if (rd !== 32'h005) begin fails++; $display("FAIL swrst_sw: got %h need 5", rd); end
        cpu_read(32'h114, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL swrst_edge: got %h need 0", rd); end
        sw = 10'h000;
        repeat (3) @(negedge clk);
        cpu_read(32'h114, rd);
        tests++;
        if (rd !== 32'h005) begin fails++; $display("FAIL swrst_fall_edge: got %h need 5", rd); end
        cpu_write(32'h114, 32'h3FF);
        cpu_read(32'h114, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL swrst_clr: got %h need 0", rd); end
        @(negedge clk);
    endtask

    task automatic test_leds();
        logic [31:0] rd;
        cpu_write(32'h104, 32'h3FF);
        tests++;
        if (leds !== 10'h3FF) begin fails++; $display("FAIL leds_write: got %h need 3ff", leds); end
        cpu_read(32'h104, rd);
        tests++;
        if (rd !== 32'h3FF) begin fails++; $display("FAIL leds_read: got %h need 3ff", rd); end
        @(negedge clk);
        cpu_write(32'h004, 32'h0AA);
        tests++;
        if (leds !== 10'h3FF) begin fails++; $display("FAIL leds_iosel0: got %h need 3ff", leds); end
        cpu_write(32'h10C, 32'hFFFF_FFFF);
        cpu_read(32'h10C, rd);
        tests++;
        if (rd !== 32'h3F) begin fails++; $display("FAIL blank_width: got %h need 3f", rd); end
        cpu_read(32'h100, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL unmapped_00: got %h need 0", rd); end
        cpu_read(32'h128, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL unmapped_28: got %h need 0", rd); end
        @(negedge clk);
    endtask

    task automatic test_hex();
        logic [31:0] rd;
        cpu_write(32'h108, 32'h0012_3456);
        cpu_write(32'h10C, 32'h01);
        tests++;
        if (hex[6:0] !== 7'h7F) begin fails++; $display("FAIL hex0_blank: got %h need 7f", hex[6:0]); end
        tests++;
        if (hex[13:7] !== 7'h12) begin fails++; $display("FAIL hex1_five: got %h need 12", hex[13:7]); end
        tests++;
        if (hex[41:35] !== 7'h79) begin fails++; $display("FAIL hex5_one: got %h need 79", hex[41:35]); end
        tests++;
        if (hex[20:14] !== 7'h19) begin fails++; $display("FAIL hex2_four: got %h need 19", hex[20:14]); end
        cpu_read(32'h108, rd);
        tests++;
        if (rd !== 32'h0012_3456) begin fails++; $display("FAIL hex_read: got %h need 123456", rd); end
        @(negedge clk);
    endtask

    task automatic test_sw();
        logic [31:0] rd;
        sw = 10'h008;
        @(negedge clk);
        cpu_read(32'h110, rd);
        tests++;
        if (rd !== 32'h000) begin fails++; $display("FAIL sw_lat1: got %h need 0", rd); end
        @(negedge clk);
        cpu_read(32'h110, rd);
        tests++;
        if (rd !== 32'h008) begin fails++; $display("FAIL sw_lat2: got %h need 8", rd); end
        cpu_read(32'h114, rd);
        tests++;
        if (rd !== 32'h008) begin fails++; $display("FAIL sw_edge_set: got %h need 8", rd); end
        @(negedge clk);
        cpu_write(32'h114, 32'h008);
        cpu_read(32'h114, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL sw_edge_clr: got %h need 0", rd); end
        @(negedge clk);
    endtask

    task automatic test_timer();
        logic [31:0] rd;
        cpu_write(32'h11C, 32'd5);
        cpu_write(32'h118, 32'd0);
        cpu_write(32'h120, 32'h7);
        repeat (5) @(negedge clk);
        cpu_read(32'h118, rd);
        tests++;
        if (rd !== 32'd5) begin fails++; $display("FAIL tmr_count5: got %h need 5", rd); end
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL tmr_irq_early: got %b need 0", irq); end
        @(negedge clk);
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL tmr_irq_set: got %b need 1", irq); end
        cpu_read(32'h118, rd);
        tests++;
        if (rd !== 32'd0) begin fails++; $display("FAIL tmr_reload: got %h need 0", rd); end
        cpu_read(32'h124, rd);
        tests++;
        if (rd !== 32'd1) begin fails++; $display("FAIL tmr_tstat: got %h need 1", rd); end
        @(negedge clk);
        cpu_write(32'h124, 32'd1);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL tmr_irq_clr: got %b need 0", irq); end
        cpu_write(32'h120, 32'h0);
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        cpu_write(32'h118, 32'hFFFF_FFFF);
        cpu_write(32'h120, 32'h1);
        cpu_read(32'h118, rd);
        tests++;
        if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_hold: got %h need ffffffff", rd); end
        @(negedge clk);
        cpu_read(32'h118, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL wrap_zero: got %h need 0", rd); end
        @(negedge clk);
        cpu_write(32'h120, 32'h0);
        cpu_read(32'h124, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL wrap_nopend: got %h need 0", rd); end
        @(negedge clk);
    endtask

    task automatic test_match_write();
        logic [31:0] rd;
        cpu_write(32'h11C, 32'd10);
        cpu_write(32'h118, 32'd8);
        cpu_write(32'h120, 32'h7);
        repeat (2) @(negedge clk);
        cpu_read(32'h118, rd);
        tests++;
        if (rd !== 32'd10) begin fails++; $display("FAIL match_pre: got %h need a", rd); end
        @(negedge clk);
        cpu_write(32'h118, 32'h1234);
        cpu_read(32'h118, rd);
        tests++;
        if (rd !== 32'h1234) begin fails++; $display("FAIL match_wr_wins: got %h need 1234", rd); end
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL match_irq: got %b need 1", irq); end
        @(negedge clk);
        cpu_write(32'h120, 32'h0);
        cpu_write(32'h124, 32'h1);
        cpu_write(32'h11C, 32'd21);
        cpu_write(32'h118, 32'd20);
        cpu_write(32'h120, 32'h3);
        @(negedge clk);
        cpu_write(32'h124, 32'h1);
        cpu_read(32'h124, rd);
        tests++;
        if (rd !== 32'd1) begin fails++; $display("FAIL pend_beats_clr: got %h need 1", rd); end
        cpu_read(32'h118, rd);
        tests++;
        if (rd !== 32'd22) begin fails++; $display("FAIL no_reload_inc: got %h need 16", rd); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        cpu_write(32'h104, 32'h2AA);
        @(posedge clk);
        #3;
        addr    = 32'h118;
        reset_n = 1'b0;
        #1;
        tests++;
        if (leds !== 10'h000) begin fails++; $display("FAIL arst_leds: got %h need 0", leds); end
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL arst_irq: got %b need 0", irq); end
        tests++;
        if (hex !== HEX_RST) begin fails++; $display("FAIL arst_hex: got %h need %h", hex, HEX_RST); end
        tests++;
        if (io_rdata !== 32'h0) begin fails++; $display("FAIL arst_tcount: got %h need 0", io_rdata); end
        addr      = 32'h104;
        writedata = 32'h155;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (leds !== 10'h000) begin fails++; $display("FAIL arst_write: got %h need 0", leds); end
        memwrite = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        cpu_read(32'h118, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL arst_stopped: got %h need 0", rd); end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset_n   = 1'b0;
        addr      = 32'h0;
        writedata = 32'h0;
        memwrite  = 1'b0;
        sw        = 10'h000;
        repeat (3) @(negedge clk);
        test_reset();
        test_sw_reset();
        test_leds();
        test_hex();
        test_sw();
        test_timer();
        test_wrap();
        test_match_write();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
